// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : Universal shift register with hold, shift-left, shift-right
//                and parallel load. Tracks the number of shifts since the
//                last load or reset (saturating at WIDTH) and pulses done
//                for one cycle when that count first reaches WIDTH.
//                Optional macro UNIV_SHIFT_REG_ROTATE_EN adds a rotate input
//                that feeds the outgoing edge bit back into the vacated
//                position instead of serial_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] d,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  // Operation encoding on the mode input
  localparam logic [1:0] C_MODE_HOLD  = 2'b00;
  localparam logic [1:0] C_MODE_LEFT  = 2'b01;
  localparam logic [1:0] C_MODE_RIGHT = 2'b10;
  localparam logic [1:0] C_MODE_LOAD  = 2'b11;

  // Shift count at which the counter saturates and done fires
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  // State registers and their next-state values
  logic [WIDTH-1:0] q_q,    q_d;
  logic             so_q,   so_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic             done_q, done_d;

  // Bits entering the vacated position for each shift direction
  logic w_in_left;
  logic w_in_right;

  // Shift-count bookkeeping shared by both shift directions
  logic [CW-1:0] w_cnt_inc;
  logic          w_cnt_hits_max;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  // Rotation recirculates the bit leaving the opposite end
  always_comb begin
    w_in_left  = rotate ? q_q[WIDTH-1] : serial_in;
    w_in_right = rotate ? q_q[0]       : serial_in;
  end
`else
  // Without rotation the vacated bit always comes from serial_in
  always_comb begin
    w_in_left  = serial_in;
    w_in_right = serial_in;
  end
`endif

  // Saturating increment; done only on the WIDTH-1 -> WIDTH transition
  always_comb begin
    w_cnt_hits_max = (cnt_q == C_CNT_LAST);
    if (cnt_q < C_CNT_MAX) begin
      w_cnt_inc = cnt_q + C_CNT_ONE;
    end else begin
      w_cnt_inc = cnt_q;
    end
  end

  // Next-state selection: hold everything unless enabled, done defaults low
  always_comb begin
    q_d    = q_q;
    so_d   = so_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode)
        C_MODE_HOLD: begin
          q_d = q_q;
        end
        C_MODE_LEFT: begin
          q_d    = {q_q[WIDTH-2:0], w_in_left};
          so_d   = q_q[WIDTH-1];
          cnt_d  = w_cnt_inc;
          done_d = w_cnt_hits_max;
        end
        C_MODE_RIGHT: begin
          q_d    = {w_in_right, q_q[WIDTH-1:1]};
          so_d   = q_q[0];
          cnt_d  = w_cnt_inc;
          done_d = w_cnt_hits_max;
        end
        C_MODE_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= '0;
      so_q   <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      so_q   <= so_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // All outputs come straight from registers
  assign q          = q_q;
  assign serial_out = so_q;
  assign shift_cnt  = cnt_q;
  assign done       = done_q;

endmodule
`default_nettype wire
